dm_hart_runctrl: RTL and testbench



---
 rtl/dm_hart_runctrl.sv | 133 +++++++++++++
 tb/tb_dm_hart_runctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_hart_runctrl.sv
// rtl/dm_hart_runctrl.sv - multi-hart halt/resume run control with dmstatus summary
module dm_hart_runctrl #(
  parameter int unsigned        NrHarts         = 4,
  parameter logic [NrHarts-1:0] SelectableHarts = {NrHarts{1'b1}},
  parameter int unsigned        AckTimeout      = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               dmactive_i,
  input  logic [19:0]        hartsel_i,
  input  logic               hasel_i,
  input  logic [NrHarts-1:0] hawindow_i,
  input  logic               haltreq_i,
  input  logic               resumereq_i,
  input  logic               ackhavereset_i,
  input  logic               clear_timeout_i,
  input  logic [NrHarts-1:0] halted_i,
  input  logic [NrHarts-1:0] unavailable_i,
  input  logic [NrHarts-1:0] havereset_i,
  output logic [NrHarts-1:0] debug_req_o,
  output logic [NrHarts-1:0] resume_o,
  output logic [11:0]        status_o,
  output logic               resume_timeout_o
);

  localparam int unsigned     CntW    = $clog2(AckTimeout + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(AckTimeout - 1);

  typedef enum logic {RS_IDLE, RS_PENDING} rs_e;

  rs_e                state_q [NrHarts];
  rs_e                state_d [NrHarts];
  logic [CntW-1:0]    cnt_q   [NrHarts];
  logic [CntW-1:0]    cnt_d   [NrHarts];
  logic [NrHarts-1:0] resumeack_q, resumeack_d;
  logic [NrHarts-1:0] havereset_q;
  logic [NrHarts-1:0] debug_req_q, debug_req_d;
  logic [NrHarts-1:0] fire;
  logic               timeout_q, timeout_d;

  logic [NrHarts-1:0] hs_match, sel, halted_v, running_v;
  logic               any_sel, hartsel_exists;

  always_comb begin
    for (int i = 0; i < NrHarts; i++) begin
      hs_match[i] = (hartsel_i == 20'(i)) & SelectableHarts[i];
    end
    sel            = hs_match | ({NrHarts{hasel_i}} & hawindow_i & SelectableHarts);
    any_sel        = |sel;
    hartsel_exists = |hs_match;
  end

  // A pending halt request persists until the hart reports halted or haltreq drops.
  assign debug_req_d = (debug_req_q | ({NrHarts{haltreq_i}} & sel & ~halted_i & ~unavailable_i))
                       & ~halted_i & {NrHarts{haltreq_i}};

  always_comb begin
    fire        = '0;
    resumeack_d = resumeack_q;
    for (int i = 0; i < NrHarts; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        RS_IDLE: begin
          if (resumereq_i & sel[i] & halted_i[i] & ~unavailable_i[i] & ~haltreq_i) begin
            state_d[i]     = RS_PENDING;
            cnt_d[i]       = '0;
            resumeack_d[i] = 1'b0;
          end
        end
        RS_PENDING: begin
          if (!halted_i[i]) begin
            state_d[i]     = RS_IDLE;
            resumeack_d[i] = 1'b1;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = RS_IDLE;
            fire[i]    = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      endcase
    end
    // A timeout in the same cycle as clear_timeout_i keeps the flag set.
    timeout_d = (|fire) | (timeout_q & ~clear_timeout_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !dmactive_i) begin
      state_q     <= '{default: RS_IDLE};
      cnt_q       <= '{default: '0};
      resumeack_q <= '0;
      debug_req_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      resumeack_q <= resumeack_d;
      debug_req_q <= debug_req_d;
      timeout_q   <= timeout_d;
    end
  end

  // havereset survives dmactive_i=0; only a full reset reloads it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      havereset_q <= SelectableHarts;
    end else begin
      havereset_q <= havereset_i | (havereset_q & ~({NrHarts{ackhavereset_i}} & sel));
    end
  end

  always_comb begin
    for (int i = 0; i < NrHarts; i++) begin
      resume_o[i] = (state_q[i] == RS_PENDING);
    end
  end

  assign debug_req_o      = debug_req_q;
  assign resume_timeout_o = timeout_q;
  assign halted_v         = halted_i & ~unavailable_i;
  assign running_v        = ~halted_i & ~unavailable_i;

  assign status_o = {
    |(halted_v & sel),        any_sel & (&(halted_v | ~sel)),
    |(running_v & sel),       any_sel & (&(running_v | ~sel)),
    |(unavailable_i & sel),   any_sel & (&(unavailable_i | ~sel)),
    ~hartsel_exists,          ~hartsel_exists & ~any_sel,
    |(resumeack_q & sel),     any_sel & (&(resumeack_q | ~sel)),
    |(havereset_q & sel),     any_sel & (&(havereset_q | ~sel))
  };

endmodule

// File: tb/tb_dm_hart_runctrl.sv
// tb/tb_dm_hart_runctrl.sv - scoreboard bench for dm_hart_runctrl against a behavioural model
module tb_dm_hart_runctrl;
  localparam int N = 4;
  localparam int AT = 8;
  localparam logic [N-1:0] SELH = 4'b1111;

  localparam logic [20:0] M_DREQ = 21'h1E0000;
  localparam logic [20:0] M_RES  = 21'h01E000;
  localparam logic [20:0] M_ST   = 21'h001FFE;
  localparam logic [20:0] M_TMO  = 21'h000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, dmactive, hasel, haltreq, resumereq, ackhr, clrto;
  logic [19:0] hartsel;
  logic [N-1:0] hawindow, halted, unavail, hr_in;
  logic [N-1:0] dreq, resume;
  logic [11:0] status;
  logic tmo;

  dm_hart_runctrl #(.NrHarts(N), .SelectableHarts(SELH), .AckTimeout(AT)) dut (
    .clk_i(clk), .rst_i(rst), .dmactive_i(dmactive), .hartsel_i(hartsel),
    .hasel_i(hasel), .hawindow_i(hawindow), .haltreq_i(haltreq),
    .resumereq_i(resumereq), .ackhavereset_i(ackhr), .clear_timeout_i(clrto),
    .halted_i(halted), .unavailable_i(unavail), .havereset_i(hr_in),
    .debug_req_o(dreq), .resume_o(resume), .status_o(status),
    .resume_timeout_o(tmo)
  );

  typedef struct {
    logic [20:0] want;
    logic [20:0] kmask;
    logic [20:0] kval;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;
  bit done = 0;

  // Reference model: per-hart flags plus the number of cycles resume has been held.
  bit m_dreq[N], m_pend[N], m_ack[N], m_hr[N];
  int m_age[N];
  bit m_tmo;

  function automatic bit is_sel(int i);
    return ((hartsel == 20'(i)) || (hasel && hawindow[i])) && SELH[i];
  endfunction

  function automatic logic [11:0] model_status();
    int nsel = 0, nh = 0, nr = 0, nu = 0, na = 0, nhr = 0;
    int hs;
    bit exists;
    for (int i = 0; i < N; i++) begin
      if (is_sel(i)) begin
        nsel++;
        if (halted[i] && !unavail[i]) nh++;
        if (!halted[i] && !unavail[i]) nr++;
        if (unavail[i]) nu++;
        if (m_ack[i]) na++;
        if (m_hr[i]) nhr++;
      end
    end
    hs = int'(hartsel);
    exists = (hs < N) ? SELH[hs] : 1'b0;
    return {nh > 0, nsel > 0 && nh == nsel, nr > 0, nsel > 0 && nr == nsel,
            nu > 0, nsel > 0 && nu == nsel, !exists, !exists && nsel == 0,
            na > 0, nsel > 0 && na == nsel, nhr > 0, nsel > 0 && nhr == nsel};
  endfunction

  function automatic logic [20:0] model_vec();
    logic [20:0] v = '0;
    for (int i = 0; i < N; i++) begin
      v[17+i] = m_dreq[i];
      v[13+i] = m_pend[i];
    end
    v[12:1] = model_status();
    v[0] = m_tmo;
    return v;
  endfunction

  function automatic void model_step();
    bit fired = 0;
    bit s[N];
    for (int i = 0; i < N; i++) s[i] = is_sel(i);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_dreq[i] = 0; m_pend[i] = 0; m_ack[i] = 0; m_hr[i] = SELH[i]; m_age[i] = 0;
      end
      m_tmo = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (hr_in[i]) m_hr[i] = 1;
      else if (ackhr && s[i]) m_hr[i] = 0;
    end
    if (!dmactive) begin
      for (int i = 0; i < N; i++) begin
        m_dreq[i] = 0; m_pend[i] = 0; m_ack[i] = 0;
      end
      m_tmo = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (halted[i] || !haltreq) m_dreq[i] = 0;
      else if (s[i] && !unavail[i]) m_dreq[i] = 1;
      if (m_pend[i]) begin
        if (!halted[i]) begin
          m_pend[i] = 0; m_ack[i] = 1;
        end else if (m_age[i] == AT) begin
          m_pend[i] = 0; fired = 1;
        end else begin
          m_age[i]++;
        end
      end else if (resumereq && s[i] && halted[i] && !unavail[i] && !haltreq) begin
        m_pend[i] = 1; m_age[i] = 1; m_ack[i] = 0;
      end
    end
    if (fired) m_tmo = 1;
    else if (clrto) m_tmo = 0;
  endfunction

  function automatic logic [20:0] f_dreq(input logic [3:0] v); return {v, 17'b0}; endfunction
  function automatic logic [20:0] f_res(input logic [3:0] v);  return {4'b0, v, 13'b0}; endfunction
  function automatic logic [20:0] f_st(input logic [11:0] v);  return {8'b0, v, 1'b0}; endfunction

  task automatic cyc(input logic [20:0] kmask = '0, input logic [20:0] kval = '0,
                     input string tag = "");
    exp_t e;
    e.want = model_vec(); e.kmask = kmask; e.kval = kval; e.tag = tag;
    sbq.push_back(e);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input logic [20:0] act, input logic [20:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  initial begin
    exp_t e;
    logic [20:0] act;
    while (!done) begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        act = {dreq, resume, status, tmo};
        chk("debug_req", {17'b0, act[20:17]}, {17'b0, e.want[20:17]});
        chk("resume", {17'b0, act[16:13]}, {17'b0, e.want[16:13]});
        chk("status", {9'b0, act[12:1]}, {9'b0, e.want[12:1]});
        chk("timeout", {20'b0, act[0]}, {20'b0, e.want[0]});
        if (e.kmask != '0) chk(e.tag, act & e.kmask, e.kval);
      end
    end
    chk("queue_drained", 21'(sbq.size()), 21'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    rst = 1; dmactive = 1; hasel = 0; haltreq = 0; resumereq = 0; ackhr = 0; clrto = 0;
    hartsel = '0; hawindow = '0; halted = '0; unavail = '0; hr_in = '0;
    @(posedge clk); model_step();
    @(posedge clk); model_step();
    #1; rst = 0;
    cyc(M_DREQ | M_RES | M_ST | M_TMO, f_st(12'h303), "reset_state");

    hasel = 1; hawindow = 4'b1111; ackhr = 1; cyc(); ackhr = 0;

    hawindow = 4'b0110; haltreq = 1; cyc();
    halted = 4'b0010;
    cyc(M_DREQ | f_st(12'hC00), f_dreq(4'b0111) | f_st(12'h800), "halt_window");
    cyc(M_DREQ, f_dreq(4'b0101), "halt_clear");
    haltreq = 0; halted = 4'b0110; cyc(); cyc();

    hasel = 0; hartsel = 20'd2; resumereq = 1; cyc(); resumereq = 0;
    cyc(M_RES, f_res(4'b0100), "resume_rise");
    cyc(); cyc();
    halted = 4'b0010; cyc();
    cyc(M_RES | f_st(12'h00C), f_st(12'h00C), "resume_ack");

    halted = 4'b0110; resumereq = 1; cyc(); resumereq = 0;
    for (int k = 0; k < AT; k++) cyc(M_RES, f_res(4'b0100), "timeout_hold");
    cyc(M_RES | M_TMO | f_st(12'h004), M_TMO, "timeout_fire");
    clrto = 1; cyc(); clrto = 0;
    cyc(M_TMO, '0, "timeout_clear");

    haltreq = 1; resumereq = 1; cyc(); resumereq = 0;
    cyc(M_RES, '0, "conflict");
    haltreq = 0;
    hartsel = '0; hr_in = 4'b0001; ackhr = 1; cyc(); hr_in = '0; ackhr = 0;
    cyc(f_st(12'h003), f_st(12'h003), "hr_set_wins");

    hartsel = 20'd7; cyc(M_ST, f_st(12'h030), "nonexist");

    hartsel = 20'd2; hasel = 1; hawindow = 4'b0001; resumereq = 1; cyc(); resumereq = 0; cyc();
    dmactive = 0; cyc(); dmactive = 1;
    cyc(M_RES | f_st(12'h00F), f_st(12'h002), "dmactive_off");

    hasel = 0; resumereq = 1; cyc(); resumereq = 0; cyc();
    rst = 1; resumereq = 1; cyc(); rst = 0; resumereq = 0;
    cyc(M_RES | f_st(12'h003), f_st(12'h003), "rst_pending");

    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 599) == 0);
      dmactive  = ($urandom_range(0, 79) != 0);
      hartsel   = 20'($urandom_range(0, 6));
      hasel     = 1'($urandom_range(0, 1));
      hawindow  = 4'($urandom);
      haltreq   = ($urandom_range(0, 5) == 0);
      resumereq = ($urandom_range(0, 3) == 0);
      ackhr     = ($urandom_range(0, 9) == 0);
      clrto     = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) halted[i] = ~halted[i];
        if ($urandom_range(0, 39) == 0) unavail[i] = ~unavail[i];
        hr_in[i] = ($urandom_range(0, 15) == 0);
      end
      cyc();
    end
    rst = 0; dmactive = 1; resumereq = 0; ackhr = 0; clrto = 0; hr_in = '0;
    cyc();
    done = 1;
  end

endmodule
